// File: rtl/execute_muldiv_unit_pkg.sv
// Shared op encodings, FSM states and op-decode helpers for the execute-stage multiply/divide unit.
package execute_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_ITER = 2'b10,
        S_FIX  = 2'b11
    } md_state_e;

    function automatic logic op_is_div(input md_op_e o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input md_op_e o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/execute_muldiv_unit_negate.sv
// Conditional two's-complement of an N-bit value; used for operand magnitudes and result sign fix-up.
module execute_muldiv_unit_negate #(
    parameter int unsigned N = 64
) (
    input  logic         neg,
    input  logic [N-1:0] value,
    output logic [N-1:0] result_c
);

    localparam logic [N-1:0] ONE = N'(1);

    always_comb begin
        result_c = neg ? (~value + ONE) : value;
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit owning the HI/LO pair; busy stalls HI/LO readers.
module execute_muldiv_unit
    import execute_muldiv_unit_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mt_hi,
    input  logic         mt_lo,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic         div0,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int unsigned W2    = 2 * W;
    localparam int unsigned CNT_W = $clog2(W) + 1;

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     opd_q, opd_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic             dz_q, dz_d;
    logic             busy_d, done_d, div0_d;
    logic [W-1:0]     hi_d, lo_d;
    logic             accept;

    logic             is_div_q, sgn_q;
    logic [W-1:0]     abs_a, abs_b;
    logic [W:0]       mul_sum, rem_sh;
    logic [W-1:0]     rem_diff;
    logic             rem_ge;
    logic [W2-1:0]    step_acc, res_in, res_out;
    logic [W-1:0]     rem_out;

    assign is_div_q = op_is_div(op_q);
    assign sgn_q    = op_is_signed(op_q);

    // Operand magnitudes; unsigned ops pass straight through.
    execute_muldiv_unit_negate #(.N(W)) u_abs_a (
        .neg      (sgn_q & a_q[W-1]),
        .value    (a_q),
        .result_c (abs_a)
    );

    execute_muldiv_unit_negate #(.N(W)) u_abs_b (
        .neg      (sgn_q & b_q[W-1]),
        .value    (b_q),
        .result_c (abs_b)
    );

    // One iteration: shift-add multiply or restoring shift-subtract divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        rem_sh   = acc_q[W2-1:W-1];
        rem_ge   = (rem_sh >= {1'b0, opd_q});
        rem_diff = W'(rem_sh - {1'b0, opd_q});
        if (is_div_q) begin
            step_acc = rem_ge ? {rem_diff, acc_q[W-2:0], 1'b1}
                              : {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            step_acc = {mul_sum, acc_q[W-1:1]};
        end
        res_in = is_div_q ? {{W{1'b0}}, step_acc[W-1:0]} : step_acc;
    end

    // Sign fix-up of the final iteration: full product, or quotient and remainder separately.
    execute_muldiv_unit_negate #(.N(W2)) u_fix_res (
        .neg      (neg_lo_q),
        .value    (res_in),
        .result_c (res_out)
    );

    execute_muldiv_unit_negate #(.N(W)) u_fix_rem (
        .neg      (neg_hi_q),
        .value    (step_acc[W2-1:W]),
        .result_c (rem_out)
    );

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi;
        lo_d     = lo;
        div0_d   = div0;
        done_d   = 1'b0;
        accept   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                end else begin
                    if (mt_hi) hi_d = a;
                    if (mt_lo) lo_d = a;
                end
            end
            S_LOAD: begin
                state_d  = S_ITER;
                cnt_d    = CNT_W'(W);
                acc_d    = {{W{1'b0}}, is_div_q ? abs_a : abs_b};
                opd_d    = is_div_q ? abs_b : abs_a;
                neg_lo_d = sgn_q & (a_q[W-1] ^ b_q[W-1]);
                neg_hi_d = is_div_q ? (sgn_q & a_q[W-1]) : (sgn_q & (a_q[W-1] ^ b_q[W-1]));
                dz_d     = is_div_q & (b_q == '0);
                if (is_div_q && (b_q == '0)) div0_d = 1'b1;
            end
            S_ITER: begin
                // Divide-by-zero keeps the datapath frozen so it completes at the normal latency.
                if (!dz_q) acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                    done_d  = 1'b1;
                    if (dz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        hi_d = rem_out;
                        lo_d = res_out[W-1:0];
                    end else begin
                        hi_d = res_out[W2-1:W];
                        lo_d = res_out[W-1:0];
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (start) accept = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_LOAD;
            op_d    = md_op_e'(op);
            a_d     = a;
            b_d     = b;
            div0_d  = 1'b0;
        end

        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            div0_d  = 1'b0;
            hi_d    = hi;
            lo_d    = lo;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= MD_MULT;
            a_q      <= '0;
            b_q      <= '0;
            opd_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div0     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            busy     <= busy_d;
            done     <= done_d;
            div0     <= div0_d;
            hi       <= hi_d;
            lo       <= lo_d;
        end
    end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Scoreboard bench for execute_muldiv_unit: expected HI/LO/div0 queued at launch, compared at done.
module tb_execute_muldiv_unit;

    localparam int unsigned W   = 32;
    localparam int          LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         mt_hi = 1'b0;
    logic         mt_lo = 1'b0;
    logic         flush = 1'b0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int launch_cyc = 0;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } exp_t;

    exp_t exp_q[$];

    execute_muldiv_unit #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mt_hi (mt_hi),
        .mt_lo (mt_lo),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sq, sr;
        logic [63:0] ux, uy, uq, ur;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        model = '0;
        case (o)
            2'b00: model = sx * sy;
            2'b01: model = ux * uy;
            2'b10: begin
                if (y == 32'd0) model = {x, 32'hFFFF_FFFF};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    model = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) model = {x, 32'hFFFF_FFFF};
                else begin
                    uq = ux / uy;
                    ur = ux % uy;
                    model = {ur[31:0], uq[31:0]};
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
        exp_t e;
        logic [63:0] m;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        launch_cyc = cyc;
        if (push) begin
            m = model(o, x, y);
            e.hi = m[63:32];
            e.lo = m[31:0];
            e.div0 = o[1] && (y == 32'd0);
            exp_q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout done=%b required 1 within 200 cycles", name, done);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            return;
        end
        checks++;
        if (cyc - launch_cyc != LAT) begin
            errors++;
            $display("FAIL %s_latency got %0d required %0d", name, cyc - launch_cyc, LAT);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_at_done got %b required 1", name, busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected_done scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (hi !== e.hi) begin
            errors++;
            $display("FAIL %s_hi got %h required %h", name, hi, e.hi);
        end
        checks++;
        if (lo !== e.lo) begin
            errors++;
            $display("FAIL %s_lo got %h required %h", name, lo, e.lo);
        end
        checks++;
        if (div0 !== e.div0) begin
            errors++;
            $display("FAIL %s_div0 got %b required %b", name, div0, e.div0);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({busy, done, div0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b required 000", {busy, done, div0});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hilo got %h required 0", {hi, lo});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        tick();
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("multu_max");
        tick();
        launch(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_done("mult_neg3x7");
        tick();
        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("mult_minxmin");
        tick();
        launch(2'b00, 32'h0001_2345, 32'hFFFF_FF00, 1'b1);
        wait_done("mult_mixed");
    endtask

    task automatic test_div();
        tick();
        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("div_neg7by2");
        tick();
        launch(2'b11, 32'd100, 32'd7, 1'b1);
        wait_done("divu_100by7");
        tick();
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_min_by_m1");
        tick();
        launch(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done("div_7by_m2");
        tick();
        launch(2'b11, 32'hFFFF_FFFF, 32'd3, 1'b1);
        wait_done("divu_max_by3");
    endtask

    task automatic test_div0();
        tick();
        launch(2'b11, 32'd5, 32'd0, 1'b1);
        wait_done("divu_by0");
        tick();
        launch(2'b01, 32'd2, 32'd3, 1'b1);
        checks++;
        if (div0 !== 1'b0) begin
            errors++;
            $display("FAIL div0_clear_on_start got %b required 0", div0);
        end
        wait_done("after_div0");
    endtask

    task automatic test_mt();
        logic [W-1:0] hs, ls;
        tick();
        a = 32'h1234_5678;
        mt_hi = 1'b1;
        tick();
        mt_hi = 1'b0;
        checks++;
        if (hi !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mthi got %h required 12345678", hi);
        end
        a = 32'h9ABC_DEF0;
        mt_lo = 1'b1;
        tick();
        mt_lo = 1'b0;
        checks++;
        if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h required 12345678 9abcdef0", hi, lo);
        end
        hs = hi;
        ls = lo;
        mt_hi = 1'b1;
        mt_lo = 1'b1;
        launch(2'b01, 32'd3, 32'd5, 1'b1);
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        checks++;
        if (hi !== hs || lo !== ls) begin
            errors++;
            $display("FAIL mt_dropped_on_start got %h_%h required %h_%h", hi, lo, hs, ls);
        end
        wait_done("start_wins_over_mt");
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] hs;
        tick();
        launch(2'b01, 32'd6, 32'd7, 1'b1);
        repeat (5) tick();
        hs = hi;
        op = 2'b11;
        a = 32'd99;
        b = 32'd1;
        start = 1'b1;
        mt_hi = 1'b1;
        tick();
        start = 1'b0;
        mt_hi = 1'b0;
        checks++;
        if (hi !== hs) begin
            errors++;
            $display("FAIL mthi_while_busy got %h required %h", hi, hs);
        end
        wait_done("start_while_busy");
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_queued_start got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] hs, ls;
        int seen;
        tick();
        hs = hi;
        ls = lo;
        launch(2'b11, 32'd5, 32'd0, 1'b0);
        repeat (10) tick();
        checks++;
        if (div0 !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got div0=%b busy=%b required 1 1", div0, busy);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || div0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_div0 got busy=%b div0=%b required 0 0", busy, div0);
        end
        seen = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_done got %0d done pulses required 0", seen);
        end
        checks++;
        if (hi !== hs || lo !== ls) begin
            errors++;
            $display("FAIL flush_hilo got %h_%h required %h_%h", hi, lo, hs, ls);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        launch(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b1);
        wait_done("b2b_first");
        launch(2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        wait_done("b2b_second");
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        logic [1:0] o;
        for (int i = 0; i < 8; i++) begin
            tick();
            o = 2'($urandom_range(0, 3));
            x = $urandom();
            y = (i == 3) ? 32'd0 : ((i == 5) ? 32'h8000_0000 : $urandom());
            launch(o, x, y, 1'b1);
            wait_done("random");
        end
    endtask

    task automatic test_async_reset();
        tick();
        launch(2'b01, 32'd11, 32'd13, 1'b0);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_flags got busy=%b done=%b div0=%b required 0 0 0", busy, done, div0);
        end
        checks++;
        if (hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL async_reset_hilo got %h_%h required 0_0", hi, lo);
        end
        tick();
        rst_n = 1'b1;
        tick();
        launch(2'b11, 32'd100, 32'd7, 1'b1);
        wait_done("after_async_reset");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_mt();
        test_busy_ignore();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
